// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory / MMIO responder: register offsets,
// STATUS bit positions and the decode-region type.
package dmem_pkg;

  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h1000_0000;

  localparam logic [3:0] OFF_TX_DATA = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_CYCLE   = 4'h8;
  localparam logic [3:0] OFF_GPIO    = 4'hC;

  localparam int unsigned STATUS_EMPTY_BIT = 8;
  localparam int unsigned STATUS_FULL_BIT  = 9;
  localparam int unsigned STATUS_OVF_BIT   = 10;

  typedef enum logic [1:0] {
    RegionNone,
    RegionRam,
    RegionMmio
  } region_e;

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Data-memory bus plus console TX stream between a core and the responder.
interface dmem_mmio_responder_if;
  logic [3:0]  MemWrite_EN;
  logic [31:0] MemAddr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output MemWrite_EN, MemAddr, WriteData, tx_ready,
    input  ReadData, tx_data, tx_valid
  );

  modport slave (
    input  MemWrite_EN, MemAddr, WriteData, tx_ready,
    output ReadData, tx_data, tx_valid
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (count_q == CntW'(DEPTH));
    empty   = (count_q == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data memory with byte-write RAM and a 16-byte MMIO window (console TX FIFO,
// status, cycle counter, GPIO). Reads complete one cycle after the address.
module dmem_mmio_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE
) (
  input  logic                        clk,
  input  logic                        reset,
  dmem_mmio_responder_if.slave        bus,
  output logic [7:0]                  gpio_out
);
  localparam int unsigned RamAw    = $clog2(RAM_WORDS);
  localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] RamBytes = 33'(RAM_WORDS) << 2;

  region_e          region, region_q;
  logic [3:0]       mmio_off;
  logic [RamAw-1:0] ram_idx;
  logic [3:0]       ram_we;

  logic             push, pop, fifo_full, fifo_empty;
  logic [CntW-1:0]  fifo_count;
  logic [7:0]       fifo_head;

  logic             ovf_q, ovf_d, ovf_set, ovf_clr;
  logic [31:0]      cycle_q;
  logic [7:0]       gpio_q;
  logic             gpio_we;
  logic [31:0]      mmio_rdata_d, mmio_rdata_q;

  logic [31:0]      ram_mem [RAM_WORDS];
  logic [31:0]      ram_rdata_q;

  // MMIO decode takes priority over RAM should the two ever overlap.
  always_comb begin
    mmio_off = {bus.MemAddr[3:2], 2'b00};
    ram_idx  = bus.MemAddr[RamAw+1:2];
    if (bus.MemAddr[31:4] == MMIO_BASE[31:4]) begin
      region = RegionMmio;
    end else if ({1'b0, bus.MemAddr} < RamBytes) begin
      region = RegionRam;
    end else begin
      region = RegionNone;
    end
  end

  always_comb begin
    ram_we  = (region == RegionRam) ? bus.MemWrite_EN : 4'b0000;
    push    = (region == RegionMmio) && (mmio_off == OFF_TX_DATA) && bus.MemWrite_EN[0];
    pop     = bus.tx_ready && !fifo_empty;
    gpio_we = (region == RegionMmio) && (mmio_off == OFF_GPIO) && bus.MemWrite_EN[0];
    ovf_set = push && fifo_full && !pop;
    ovf_clr = (region == RegionMmio) && (mmio_off == OFF_STATUS) && bus.MemWrite_EN[1] &&
              bus.WriteData[STATUS_OVF_BIT];
    ovf_d   = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (bus.WriteData[7:0]),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // MMIO read value reflects register state before this edge's updates.
  always_comb begin
    mmio_rdata_d = '0;
    case (mmio_off)
      OFF_STATUS: begin
        mmio_rdata_d[7:0]              = 8'(fifo_count);
        mmio_rdata_d[STATUS_EMPTY_BIT] = fifo_empty;
        mmio_rdata_d[STATUS_FULL_BIT]  = fifo_full;
        mmio_rdata_d[STATUS_OVF_BIT]   = ovf_q;
      end
      OFF_CYCLE: mmio_rdata_d = cycle_q;
      OFF_GPIO:  mmio_rdata_d = {24'b0, gpio_q};
      default:   mmio_rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      region_q     <= RegionNone;
      mmio_rdata_q <= '0;
      ovf_q        <= 1'b0;
      cycle_q      <= '0;
      gpio_q       <= '0;
    end else begin
      region_q     <= region;
      mmio_rdata_q <= mmio_rdata_d;
      ovf_q        <= ovf_d;
      cycle_q      <= cycle_q + 32'd1;
      if (gpio_we) gpio_q <= bus.WriteData[7:0];
    end
  end

  // Byte-enable RAM with registered read-first output; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) ram_mem[ram_idx][8*i +: 8] <= bus.WriteData[8*i +: 8];
    end
    ram_rdata_q <= ram_mem[ram_idx];
  end

  always_comb begin
    case (region_q)
      RegionRam:  bus.ReadData = ram_rdata_q;
      RegionMmio: bus.ReadData = mmio_rdata_q;
      default:    bus.ReadData = '0;
    endcase
  end

  assign bus.tx_data  = fifo_head;
  assign bus.tx_valid = !fifo_empty;
  assign gpio_out     = gpio_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Randomized and directed bench for dmem_mmio_responder against a queue/array
// reference model of the memory map.
module tb_dmem_mmio_responder;

  localparam int unsigned RamWords  = 1024;
  localparam int unsigned FifoDepth = 8;
  localparam logic [31:0] Base      = 32'h1000_0000;
  localparam logic [31:0] Idle      = 32'h2000_0000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] gpio_out;

  dmem_mmio_responder_if bus ();

  dmem_mmio_responder #(
    .RAM_WORDS  (RamWords),
    .FIFO_DEPTH (FifoDepth),
    .MMIO_BASE  (Base)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .gpio_out (gpio_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_ram   [RamWords];
  bit          m_known [RamWords];
  logic [7:0]  m_fifo  [$];
  bit          m_ovf;
  logic [31:0] m_cyc;
  logic [7:0]  m_gpio;
  logic [31:0] init_val [64];

  // One bus cycle: drive inputs, advance the model, check outputs after the edge.
  task automatic step(input logic [3:0] en, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit rdy);
    bit          is_mmio, is_ram, empty, full, pop, set, clr, known;
    int          idx, reg_sel;
    logic [31:0] exp;
    bus.MemWrite_EN = en;
    bus.MemAddr     = addr;
    bus.WriteData   = wdata;
    bus.tx_ready    = rdy;
    is_mmio = (addr >= Base) && (addr < Base + 32'd16);
    is_ram  = !is_mmio && (addr < 4 * RamWords);
    idx     = int'((addr >> 2) % RamWords);
    reg_sel = int'((addr - Base) >> 2) % 4;
    empty   = (m_fifo.size() == 0);
    full    = (m_fifo.size() == FifoDepth);
    exp     = 32'd0;
    known   = 1'b1;
    if (is_mmio) begin
      case (reg_sel)
        1: exp = 32'(m_fifo.size()) | (32'(empty) << 8) | (32'(full) << 9) | (32'(m_ovf) << 10);
        2: exp = m_cyc;
        3: exp = {24'd0, m_gpio};
        default: exp = 32'd0;
      endcase
    end else if (is_ram) begin
      exp   = m_ram[idx];
      known = m_known[idx];
    end
    pop = rdy && !empty;
    if (pop) void'(m_fifo.pop_front());
    set = 1'b0;
    if (is_mmio && reg_sel == 0 && en[0]) begin
      if (full && !pop) set = 1'b1;
      else m_fifo.push_back(wdata[7:0]);
    end
    clr = is_mmio && reg_sel == 1 && en[1] && wdata[10];
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (is_mmio && reg_sel == 3 && en[0]) m_gpio = wdata[7:0];
    if (is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (en[i]) m_ram[idx][8*i +: 8] = wdata[8*i +: 8];
      end
      if (en == 4'hF) m_known[idx] = 1'b1;
    end
    m_cyc = m_cyc + 32'd1;
    @(posedge clk);
    #1;
    if (known) check_eq("read_data", bus.ReadData, exp);
    check_eq("tx_valid", 32'(bus.tx_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) check_eq("tx_data", 32'(bus.tx_data), 32'(m_fifo[0]));
    check_eq("gpio_out", 32'(gpio_out), 32'(m_gpio));
    @(negedge clk);
  endtask

  // Called at a falling edge; asserts reset asynchronously between edges.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    check_eq("reset_read_data", bus.ReadData, 32'd0);
    check_eq("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    check_eq("reset_gpio_out", 32'(gpio_out), 32'd0);
    m_fifo.delete();
    m_ovf  = 1'b0;
    m_cyc  = 32'd0;
    m_gpio = 8'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] r1, r2, raddr, exp_b;
  logic [3:0]  ren;

  initial begin
    bus.MemWrite_EN = 4'h0;
    bus.MemAddr     = Idle;
    bus.WriteData   = 32'd0;
    bus.tx_ready    = 1'b0;
    for (int i = 0; i < RamWords; i++) m_known[i] = 1'b0;
    @(negedge clk);
    apply_reset();

    for (int w = 0; w < 64; w++) begin
      init_val[w] = $urandom;
      step(4'hF, 32'(w * 4), init_val[w], 1'b0);
    end

    // Byte-lane merge
    step(4'hF, 32'h40, 32'hDEAD_BEEF, 1'b0);
    step(4'b0010, 32'h40, 32'h0000_5500, 1'b0);
    step(4'h0, 32'h40, 32'd0, 1'b0);
    check_eq("byte_lane_merge", bus.ReadData, 32'hDEAD_55EF);

    // Read-during-write returns old data
    step(4'hF, 32'h80, 32'h1122_3344, 1'b0);
    check_eq("rdw_old", bus.ReadData, init_val[32]);
    step(4'h0, 32'h80, 32'd0, 1'b0);
    check_eq("rdw_new", bus.ReadData, 32'h1122_3344);

    // Overflow on ninth push, then drain in order
    for (int b = 1; b <= 9; b++) step(4'b0001, Base, 32'(b), 1'b0);
    step(4'h0, Base + 32'h4, 32'd0, 1'b0);
    check_eq("status_full_ovf", bus.ReadData, 32'h0000_0608);
    for (int i = 1; i <= 8; i++) begin
      check_eq("drain_order", 32'(bus.tx_data), 32'(i));
      step(4'h0, Idle, 32'd0, 1'b1);
    end

    // Push and pop while full
    for (int b = 1; b <= 8; b++) step(4'b0001, Base, 32'(b), 1'b0);
    step(4'b0001, Base, 32'h0000_00AA, 1'b1);
    step(4'h0, Base + 32'h4, 32'd0, 1'b0);
    check_eq("status_push_pop_full", bus.ReadData, 32'h0000_0608);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 7) ? 32'(i + 2) : 32'h0000_00AA;
      check_eq("drain_after_push_pop", 32'(bus.tx_data), exp_b);
      step(4'h0, Idle, 32'd0, 1'b1);
    end
    step(4'b0010, Base + 32'h4, 32'h0000_0400, 1'b0);
    step(4'h0, Base + 32'h4, 32'd0, 1'b0);
    check_eq("status_cleared", bus.ReadData, 32'h0000_0100);

    // Cycle counter spacing and wrap
    apply_reset();
    step(4'h0, Base + 32'h8, 32'd0, 1'b0);
    r1 = bus.ReadData;
    check_eq("cycle_after_reset", r1, 32'd0);
    for (int i = 0; i < 9; i++) step(4'h0, Idle, 32'd0, 1'b0);
    step(4'h0, Base + 32'h8, 32'd0, 1'b0);
    r2 = bus.ReadData;
    check_eq("cycle_delta", r2 - r1, 32'd10);
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    m_cyc = 32'hFFFF_FFFF;
    step(4'h0, Base + 32'h8, 32'd0, 1'b0);
    check_eq("cycle_forced", bus.ReadData, 32'hFFFF_FFFF);
    step(4'h0, Base + 32'h8, 32'd0, 1'b0);
    check_eq("cycle_wrap", bus.ReadData, 32'd0);

    // Unmapped read, GPIO, reset mid-burst
    step(4'h0, Idle, 32'd0, 1'b0);
    check_eq("unmapped_read", bus.ReadData, 32'd0);
    step(4'b0001, Base + 32'hC, 32'h0000_00A5, 1'b0);
    check_eq("gpio_write", 32'(gpio_out), 32'h0000_00A5);
    for (int b = 0; b < 3; b++) step(4'b0001, Base, 32'h30 + 32'(b), 1'b0);
    apply_reset();
    step(4'b0001, Base, 32'h0000_005C, 1'b0);
    check_eq("post_reset_push", 32'(bus.tx_data), 32'h0000_005C);
    step(4'h0, Idle, 32'd0, 1'b1);

    // Random traffic over RAM window, MMIO window and unmapped space
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: raddr = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
        5, 6, 7:       raddr = Base + 32'($urandom_range(0, 15));
        8:             raddr = 32'h8000_0000 | 32'($urandom);
        default:       raddr = Idle;
      endcase
      ren = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step(ren, raddr, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, number of 32-bit RAM words (power of 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, console TX FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter MMIO_BASE, default 32'h1000_0000, base of the 16-byte MMIO window.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 MemWrite_EN  input  4  per-byte write strobes, bit i = byte lane i (bits 7+8i:8i); 0000 = read/idle.
REQ-007 MemAddr  input  32  byte address; bits [1:0] ignored.
REQ-008 WriteData  input  32  lane-aligned store data.
REQ-009 ReadData  output  32  registered full-word read data.
REQ-010 tx_data  output  8  FIFO head byte.
REQ-011 tx_valid  output  1  FIFO non-empty.
REQ-012 tx_ready  input  1  consumer accepts head when tx_valid & tx_ready.
REQ-013 gpio_out  output  8  GPIO output register.

Function
REQ-014 Decode: MemAddr[31:4]==MMIO_BASE[31:4] -> MMIO; MemAddr < 4*RAM_WORDS -> RAM at word MemAddr[log2(RAM_WORDS)+1:2]; else unmapped (reads 0, writes ignored).
REQ-015 Read latency SHALL be exactly 1 cycle: ReadData after edge N reflects MemAddr sampled at edge N; read performed every cycle regardless of MemWrite_EN.
REQ-016 RAM write: each lane i with MemWrite_EN[i]=1 updated; other lanes unchanged.
REQ-017 RAM read-during-write same word SHALL return old (pre-write) data.
REQ-018 MMIO +0x0 TX_DATA: write with MemWrite_EN[0]=1 pushes WriteData[7:0]; read returns 0.
REQ-019 MMIO +0x4 STATUS read: [7:0]=count, [8]=empty, [9]=full, [10]=overflow, others 0; write with lane 1 enabled and WriteData[10]=1 clears overflow.
REQ-020 MMIO +0x8 CYCLE: free-running 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF->0; read-only.
REQ-021 MMIO +0xC GPIO: lane-0 write loads gpio_out; read returns {24'b0,gpio_out}.
REQ-022 MMIO reads SHALL return state as of the sampling edge (before that edge's updates).
REQ-023 Push when full and no same-cycle pop: byte dropped, overflow set (sticky); overflow set and clear same cycle -> set wins.
REQ-024 Push and pop same cycle: both succeed, count unchanged, including when full.
REQ-025 Push into empty FIFO: tx_valid rises the following cycle (no bypass).
REQ-026 Pop only when tx_valid & tx_ready; tx_ready while empty has no effect.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; order strictly FIFO.
REQ-028 tx_data SHALL be stable while tx_valid=1 and tx_ready=0.

Reset
REQ-029 On reset: ReadData=0, FIFO empty (count 0, tx_valid 0), overflow=0, CYCLE=0, gpio_out=0.
REQ-030 RAM contents SHALL NOT be reset.
REQ-031 Reset mid-operation SHALL discard FIFO contents immediately; first push after deassert appears as normal.

Structure
REQ-032 Package dmem_pkg SHALL hold MMIO offsets (TX_DATA, STATUS, CYCLE, GPIO), STATUS bit positions, default MMIO_BASE.
REQ-033 FIFO SHALL be sub-module sync_fifo (parameter DEPTH, WIDTH) with push/pop/full/empty/count.
REQ-034 RAM SHALL be inferable as byte-write-enable block RAM.

Verification
REQ-035 Write 0xDEADBEEF EN=1111 to 0x40, then EN=0010 data 0x0000_5500 -> read 0x40 returns 0xDEAD55EF one cycle after address.
REQ-036 Write 0x11223344 to 0x80 and read 0x80 same cycle -> ReadData = old value; next read -> 0x11223344.
REQ-037 tx_ready=0, push 9 bytes 0x01..0x09 -> STATUS=0x0000_0608 (full, overflow, count 8); drain -> 0x01..0x08 in order.
REQ-038 FIFO full, push 0xAA with tx_ready=1 same cycle -> count stays 8, 0xAA last out, overflow unchanged.
REQ-039 Reset, read CYCLE 10 cycles apart -> difference 10; force 0xFFFF_FFFF -> next value 0.
REQ-040 Read 0x2000_0000 -> 0; write GPIO 0xA5 -> gpio_out=0xA5 next cycle; async reset mid-burst -> gpio_out=0, tx_valid=0 immediately.
